// File: rtl/delay_line_var.sv
`default_nettype none
// ----------------------------------------------------------------------------
// delay_line_var : runtime-programmable delay line (0..MAX_DELAY cycles)
//                  carrying a valid bit with every sample.
// Revision 1.0
// ----------------------------------------------------------------------------
module delay_line_var #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DELAY  = 8,
  localparam int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DLY_W-1:0]      delay_num,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  cfg_err
);

  localparam logic [DLY_W-1:0] C_MAX_DLY = DLY_W'(MAX_DELAY);

  logic [MAX_DELAY-1:0]  r_v;
  logic [DATA_WIDTH-1:0] r_d [MAX_DELAY];
  logic [DLY_W-1:0]      r_dly_q;
  logic                  r_cfg_err;
  logic                  r_post_rst;

  logic                  w_over;
  logic [DLY_W-1:0]      w_dly_eff;
  logic                  w_flush;
  logic                  w_sel_v;
  logic [DATA_WIDTH-1:0] w_sel_d;

  assign w_over    = (delay_num > C_MAX_DLY);
  assign w_dly_eff = w_over ? C_MAX_DLY : delay_num;
  assign w_flush   = (w_dly_eff != r_dly_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v        <= '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        r_d[i] <= '0;
      end
      r_dly_q    <= '0;
      r_cfg_err  <= 1'b0;
      r_post_rst <= 1'b1;
    end else begin
      r_post_rst <= 1'b0;
      if (w_over) begin
        r_cfg_err <= 1'b1;
      end
      if (w_flush) begin
        r_dly_q <= w_dly_eff;
      end
      if (en) begin
        r_v[0] <= in_valid;
        r_d[0] <= in_data;
        for (int i = 1; i < MAX_DELAY; i++) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
      // Flush overrides the shift for valids; only a freshly captured s[0] survives.
      if (w_flush) begin
        for (int i = 1; i < MAX_DELAY; i++) begin
          r_v[i] <= 1'b0;
        end
        if (!en) begin
          r_v[0] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sel_v = in_valid;
    w_sel_d = in_data;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (r_dly_q == DLY_W'(i + 1)) begin
        w_sel_v = r_v[i];
        w_sel_d = r_d[i];
      end
    end
    // dly_q is still 0 right after reset, so the pass-through path must be masked.
    if (r_post_rst) begin
      w_sel_v = 1'b0;
      w_sel_d = '0;
    end
  end

  assign out_valid = w_sel_v;
  assign out_data  = w_sel_d;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_var.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_delay_line_var : directed self-checking bench for delay_line_var
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_delay_line_var;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] delay_num;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       cfg_err;

  int n_total = 0;
  int n_bad   = 0;

  delay_line_var #(
    .DATA_WIDTH (8),
    .MAX_DELAY  (8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .delay_num (delay_num),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after an edge, then settle before sampling.
  task automatic step(input logic rst, input logic e, input logic [3:0] dn,
                      input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    reset     = rst;
    en        = e;
    delay_num = dn;
    in_valid  = v;
    in_data   = d;
    #1;
  endtask

  // Change delay to k (one idle cycle), then stream n samples and drain.
  task automatic run_lag(input int k, input int n, input logic [7:0] base);
    int  lag;
    bit  ev;
    lag = (k > 8) ? 8 : k;
    step(1'b0, 1'b1, 4'(k), 1'b0, 8'h00);
    for (int j = 0; j < n + lag; j++) begin
      step(1'b0, 1'b1, 4'(k), (j < n), 8'(int'(base) + j));
      ev = (j >= lag) && (j - lag < n);
      chk($sformatf("lag%0d_v[%0d]", k, j), 32'(out_valid), 32'(ev));
      if (ev) chk($sformatf("lag%0d_d[%0d]", k, j), 32'(out_data), 32'(8'(int'(base) + j - lag)));
    end
  endtask

  initial begin
    int  j;
    bit  e;
    bit  ev;

    reset = 1'b1; en = 1'b1; delay_num = 4'd0; in_valid = 1'b0; in_data = 8'h00;

    // Reset state: outputs forced low in the cycle after reset despite pass-through.
    step(1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 4'd0, 1'b1, 8'h5A);
    chk("rst_v",   32'(out_valid), 32'd0);
    chk("rst_d",   32'(out_data),  32'd0);
    chk("rst_err", 32'(cfg_err),   32'd0);

    // Zero delay: combinational pass-through.
    step(1'b0, 1'b1, 4'd0, 1'b1, 8'h3C);
    chk("pass_v", 32'(out_valid), 32'd1);
    chk("pass_d", 32'(out_data),  32'h3C);
    step(1'b0, 1'b1, 4'd0, 1'b0, 8'h77);
    chk("pass_v0", 32'(out_valid), 32'd0);
    chk("pass_d0", 32'(out_data),  32'h77);
    run_lag(0, 3, 8'h05);

    // Fixed lags 1, 2, 3 and MAX_DELAY.
    run_lag(1, 5, 8'h01);
    run_lag(2, 4, 8'h10);
    run_lag(3, 4, 8'h20);
    run_lag(8, 4, 8'h30);

    // Stall for 3 cycles mid-stream at lag 4; output freezes, order preserved.
    step(1'b0, 1'b1, 4'd4, 1'b0, 8'h00);
    j = 0;
    for (int s = 0; s < 17; s++) begin
      e = !(s >= 6 && s < 9);
      if (e) step(1'b0, 1'b1, 4'd4, (j < 10), 8'(8'h40 + j));
      else   step(1'b0, 1'b0, 4'd4, 1'b1, 8'hEE);
      ev = (j >= 4) && (j - 4 < 10);
      chk($sformatf("stall_v[%0d]", s), 32'(out_valid), 32'(ev));
      if (ev) chk($sformatf("stall_d[%0d]", s), 32'(out_data), 32'(8'(8'h40 + j - 4)));
      if (e) j++;
    end

    // Delay change 4 -> 2 with samples in flight: only the concurrent sample survives.
    step(1'b0, 1'b1, 4'd4, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd4, 1'b1, 8'(8'h50 + i));
      chk($sformatf("fill_v[%0d]", i), 32'(out_valid), 32'd0);
    end
    step(1'b0, 1'b1, 4'd2, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    chk("flush_v0", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    chk("flush_aa_v", 32'(out_valid), 32'd1);
    chk("flush_aa_d", 32'(out_data),  32'hAA);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
      chk($sformatf("flush_tail_v[%0d]", i), 32'(out_valid), 32'd0);
    end

    // Out-of-range delay: clamps to 8, sticky error survives a return to 3.
    step(1'b0, 1'b1, 4'd12, 1'b0, 8'h00);
    chk("err_pre", 32'(cfg_err), 32'd0);
    step(1'b0, 1'b1, 4'd12, 1'b0, 8'h00);
    chk("err_set", 32'(cfg_err), 32'd1);
    run_lag(12, 3, 8'h60);
    chk("err_hold1", 32'(cfg_err), 32'd1);
    run_lag(3, 3, 8'h70);
    chk("err_hold2", 32'(cfg_err), 32'd1);

    // Reset mid-stream at lag 3.
    step(1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'd3, 1'b1, 8'(8'h80 + i));
      if (i >= 3) chk($sformatf("pre_rst_d[%0d]", i), 32'(out_data), 32'(8'(8'h80 + i - 3)));
    end
    step(1'b1, 1'b1, 4'd3, 1'b1, 8'h90);
    for (int r = 0; r < 6; r++) begin
      step(1'b0, 1'b1, 4'd3, 1'b1, 8'(8'h91 + r));
      if (r == 0) begin
        chk("post_rst_v", 32'(out_valid), 32'd0);
        chk("post_rst_d", 32'(out_data),  32'd0);
        chk("post_rst_err", 32'(cfg_err), 32'd0);
      end else if (r < 3) begin
        chk($sformatf("post_rst_v[%0d]", r), 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("post_rst_v[%0d]", r), 32'(out_valid), 32'd1);
        chk($sformatf("post_rst_d[%0d]", r), 32'(out_data),  32'(8'(8'h91 + r - 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
